// File: rtl/reset_seq_n_if.sv
// Reset sequencer bundle: per-stage hold requests in, sequenced resets and
// status out. The sequencer core uses the slave modport; the hold/status
// side (power/clock monitors, bench) uses the master modport.
interface reset_seq_n_if #(
    parameter int NUM_STAGES = 3
) ();
    localparam int SW = $clog2(NUM_STAGES + 1);

    logic [NUM_STAGES-1:0] hold_in;
    logic [NUM_STAGES-1:0] rst_out;
    logic [SW-1:0]         stage;
    logic                  done;
    logic [NUM_STAGES-1:0] timeout_flag;

    modport master (
        output hold_in,
        input  rst_out,
        input  stage,
        input  done,
        input  timeout_flag
    );

    modport slave (
        input  hold_in,
        output rst_out,
        output stage,
        output done,
        output timeout_flag
    );
endinterface

// File: rtl/reset_seq_n.sv
// Parametrised reset sequencer. Releases NUM_STAGES active-high resets in
// order; stage k releases after hold_in[k] has been low for DELAYS[k]+1
// consecutive cycles. A hold on an already-released stage re-arms that stage
// and all later ones (lowest index wins). The state is the stage index
// itself; NUM_STAGES means done. Optional hold-stuck detection is built only
// when RESET_SEQ_TIMEOUT_EN is defined; otherwise timeout_flag is tied low.
module reset_seq_n #(
    parameter int                          NUM_STAGES = 3,
    parameter int                          CNT_W      = 16,
    parameter logic [NUM_STAGES*CNT_W-1:0] DELAYS     = {16'd10, 16'd10, 16'd10},
    parameter logic [31:0]                 TIMEOUT    = 32'd1000000
) (
    input logic         clk,
    input logic         rst_n,
    reset_seq_n_if.slave bus
);
    localparam int            SW       = $clog2(NUM_STAGES + 1);
    localparam logic [SW-1:0] DONE_IDX = SW'(NUM_STAGES);

    logic [SW-1:0]         state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_STAGES-1:0] rst_out_q, rst_out_d;
    logic                  done_q, done_d;

    logic                  rearm;
    logic [SW-1:0]         rearm_idx;
    logic                  hold_cur;
    logic [CNT_W-1:0]      delay_cur;

    // State register: stage index, delay counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= '0;
            cnt_q     <= '0;
            rst_out_q <= '1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_out_q <= rst_out_d;
            done_q    <= done_d;
        end
    end

    // Next state: re-arm on the lowest released stage with a hold, else count/advance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rearm     = 1'b0;
        rearm_idx = '0;
        hold_cur  = 1'b0;
        delay_cur = '0;

        // Scan downwards so the lowest requesting index is the one kept.
        for (int unsigned j = NUM_STAGES; j > 0; j--) begin
            if ((SW'(j - 1) < state_q) && bus.hold_in[j-1]) begin
                rearm     = 1'b1;
                rearm_idx = SW'(j - 1);
            end
        end

        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            if (state_q == SW'(k)) begin
                hold_cur  = bus.hold_in[k];
                delay_cur = DELAYS[k*CNT_W +: CNT_W];
            end
        end

        if (rearm) begin
            state_d = rearm_idx;
            cnt_d   = '0;
        end else if (state_q != DONE_IDX) begin
            if (hold_cur) begin
                cnt_d = '0;
            end else if (cnt_q == delay_cur) begin
                cnt_d   = '0;
                state_d = state_q + SW'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Outputs decoded from the next state so they leave the flops directly.
    always_comb begin
        done_d = (state_d == DONE_IDX);
        for (int unsigned k = 0; k < NUM_STAGES; k++) begin
            rst_out_d[k] = (SW'(k) >= state_d);
        end
    end

    assign bus.rst_out = rst_out_q;
    assign bus.stage   = state_q;
    assign bus.done    = done_q;

`ifdef RESET_SEQ_TIMEOUT_EN
    logic [31:0]           tcnt_q, tcnt_d;
    logic [NUM_STAGES-1:0] tflag_q, tflag_d;

    // Hold-stuck counter and sticky per-stage flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tcnt_q  <= '0;
            tflag_q <= '0;
        end else begin
            tcnt_q  <= tcnt_d;
            tflag_q <= tflag_d;
        end
    end

    // Count consecutive held cycles in the current stage; any stage change clears it.
    always_comb begin
        tcnt_d  = '0;
        tflag_d = tflag_q;
        if (!rearm && (state_q != DONE_IDX) && hold_cur) begin
            tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + 32'd1;
            if (tcnt_q >= TIMEOUT) begin
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    if (state_q == SW'(k)) tflag_d[k] = 1'b1;
                end
            end
        end
    end

    assign bus.timeout_flag = tflag_q;
`else
    logic unused_timeout;
    assign unused_timeout   = ^TIMEOUT;
    assign bus.timeout_flag = '0;
`endif

endmodule

// File: tb/tb_reset_seq_n.sv
// Bench for reset_seq_n: directed scenarios followed by random holds and
// resets, all compared every cycle against a run-length reference model.
module tb_reset_seq_n;
    localparam int                  N   = 3;
    localparam int                  CW  = 16;
    localparam int                  SW  = $clog2(N + 1);
    localparam int                  TO  = 20;
    localparam logic [N*CW-1:0]     DLY = {16'd10, 16'd10, 16'd10};

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reset_seq_n_if #(.NUM_STAGES(N)) bus ();

    reset_seq_n #(
        .NUM_STAGES(N),
        .CNT_W     (CW),
        .DELAYS    (DLY),
        .TIMEOUT   (32'(TO))
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: current stage, run length of low/high hold on it, flags.
    int          m_cur;
    int          m_low;
    int          m_hrun;
    logic [N-1:0] m_flag;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int dly(input int k);
        return int'(DLY[k*CW +: CW]);
    endfunction

    task automatic model_edge(input logic r, input logic [N-1:0] h);
        int j;
        if (!r) begin
            m_cur = 0; m_low = 0; m_hrun = 0; m_flag = '0;
            return;
        end
        j = -1;
        for (int i = m_cur - 1; i >= 0; i--) if (h[i]) j = i;
        if (j >= 0) begin
            m_cur = j; m_low = 0; m_hrun = 0;
        end else if (m_cur < N) begin
            if (h[m_cur]) begin
                m_low = 0;
                m_hrun++;
                if (m_hrun > TO) m_flag[m_cur] = 1'b1;
            end else begin
                m_hrun = 0;
                m_low++;
                if (m_low == dly(m_cur) + 1) begin
                    m_cur++; m_low = 0;
                end
            end
        end else begin
            m_hrun = 0;
        end
    endtask

    task automatic compare_all();
        int full;
        int mask;
        full = (1 << N) - 1;
        mask = full & ~((1 << m_cur) - 1);
        check("rst_out", 32'(bus.rst_out), 32'(mask));
        check("stage", 32'(bus.stage), 32'(m_cur));
        check("done", 32'(bus.done), 32'(m_cur == N));
`ifdef RESET_SEQ_TIMEOUT_EN
        check("timeout_flag", 32'(bus.timeout_flag), 32'(m_flag));
`else
        check("timeout_flag", 32'(bus.timeout_flag), 32'd0);
`endif
    endtask

    task automatic step(input logic r, input logic [N-1:0] h);
        rst_n       = r;
        bus.hold_in = h;
        @(posedge clk);
        model_edge(r, h);
        #1;
        compare_all();
    endtask

    int fall [N];
    int cnt;

    initial begin
        rst_n       = 1'b0;
        bus.hold_in = '0;
        m_cur = 0; m_low = 0; m_hrun = 0; m_flag = '0;

        // Reset values
        step(1'b0, '0);
        step(1'b0, '0);
        check("reset_rst_out", 32'(bus.rst_out), 32'h7);
        check("reset_stage", 32'(bus.stage), 32'd0);

        // Power-up sequence with all holds low
        for (int k = 0; k < N; k++) fall[k] = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, '0);
            for (int k = 0; k < N; k++)
                if (fall[k] == 0 && !bus.rst_out[k]) fall[k] = i + 1;
            if (i + 1 == 33) begin
                check("done_at_33", 32'(bus.done), 32'd1);
                check("stage_at_33", 32'(bus.stage), 32'd3);
            end
        end
        check("fall0_cycle", 32'(fall[0]), 32'd11);
        check("fall1_cycle", 32'(fall[1]), 32'd22);
        check("fall2_cycle", 32'(fall[2]), 32'd33);

        // DONE, one-cycle hold on stage 0 -> full resequence
        step(1'b1, 3'b001);
        check("rearm0_rst_out", 32'(bus.rst_out), 32'h7);
        check("rearm0_stage", 32'(bus.stage), 32'd0);
        check("rearm0_done", 32'(bus.done), 32'd0);
        for (int i = 0; i < 33; i++) begin
            step(1'b1, '0);
            if (i == 31) check("reseq_not_done", 32'(bus.done), 32'd0);
            if (i == 32) check("reseq_done", 32'(bus.done), 32'd1);
        end

        // DONE, holds on stages 1 and 2 together -> lowest wins
        step(1'b1, 3'b110);
        check("rearm12_rst_out", 32'(bus.rst_out), 32'h6);
        check("rearm12_stage", 32'(bus.stage), 32'd1);
        for (int i = 0; i < 30; i++) step(1'b1, '0);

        // Stage 1 hold at count 6 restarts the delay
        step(1'b0, '0);
        for (int i = 0; i < 17; i++) step(1'b1, '0);
        for (int i = 0; i < 5; i++) step(1'b1, 3'b010);
        check("hold1_stage", 32'(bus.stage), 32'd1);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, '0);
            if (cnt == 0 && !bus.rst_out[1]) cnt = i + 1;
        end
        check("hold1_release_delay", 32'(cnt), 32'd11);

        // Now in WAIT(2): one-cycle rst_n
        check("in_wait2", 32'(bus.stage), 32'd2);
        step(1'b0, '0);
        check("rstn_rst_out", 32'(bus.rst_out), 32'h7);
        check("rstn_stage", 32'(bus.stage), 32'd0);
        check("rstn_done", 32'(bus.done), 32'd0);

        // Stage 0 hold stuck for 25 cycles
        for (int i = 0; i < 25; i++) begin
            step(1'b1, 3'b001);
            if (i + 1 == 20) check("tmo_before", 32'(bus.timeout_flag[0]), 32'd0);
`ifdef RESET_SEQ_TIMEOUT_EN
            if (i + 1 == 21) check("tmo_at_21", 32'(bus.timeout_flag[0]), 32'd1);
`else
            if (i + 1 == 21) check("tmo_at_21", 32'(bus.timeout_flag[0]), 32'd0);
`endif
        end
        for (int i = 0; i < 5; i++) step(1'b1, '0);

        // Random holds and occasional resets
        for (int i = 0; i < 4000; i++) begin
            logic [N-1:0] h;
            logic         r;
            r = ($urandom_range(0, 299) != 0);
            for (int k = 0; k < N; k++) h[k] = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 499) == 0) begin
                for (int b = 0; b < 30; b++) step(r, 3'b001 << m_cur % N);
            end else begin
                step(r, h);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reset_seq_n.md
# reset_seq_n

Parametrised reset sequencer, successor to the fixed three-stage reset tree. It releases NUM_STAGES active-high reset outputs in strict order. Each stage deasserts only after its hold request has been low for a programmable number of consecutive cycles. A hold that reasserts on an already-released stage re-arms that stage and every later one. It sits at the top of each design, between clock/PLL-lock/DDR-calibration status and the downstream domain resets.

## Interface
Parameters:
- NUM_STAGES, 3: number of sequenced reset outputs, 1..16.
- CNT_W, 16: delay counter width.
- DELAYS, {16'd10,16'd10,16'd10}: packed NUM_STAGES*CNT_W vector. Stage k's delay D_k is in bits [k*CNT_W +: CNT_W]. Each D_k must be less than 2^CNT_W.
- TIMEOUT, 32'd1000000: hold-stuck threshold in cycles. Used only under RESET_SEQ_TIMEOUT_EN.

Ports:
- clk, input, 1: single clock. All logic is on its rising edge.
- rst_n, input, 1: synchronous active-low reset.
- hold_in, input, NUM_STAGES: bit k high means stage k is held in reset. This covers PLL unlocked, calibration pending, and similar conditions.
- rst_out, output, NUM_STAGES: active-high registered reset to domain k.
- stage, output, $clog2(NUM_STAGES+1): index of the stage currently counting. The value NUM_STAGES means done.
- done, output, 1: high when all stages are released.
- timeout_flag, output, NUM_STAGES: sticky per-stage hold-stuck flags.

## Operation
- Reset (rst_n low at an edge) takes priority over everything. Values after reset:
  - rst_out all ones.
  - stage 0, done 0.
  - delay counter 0.
  - timeout counter 0, timeout_flag all zero.
- States: WAIT(k) for k = 0..NUM_STAGES-1, then DONE. The stage output encodes the state directly.
- In WAIT(k):
  - hold_in[k] high: counter is cleared to 0. Requests restart the delay rather than pause it.
  - hold_in[k] low and counter not equal to D_k: counter increments.
  - hold_in[k] low and counter equal to D_k: at that edge rst_out[k] goes to 0, the counter clears, and stage becomes k+1. If k is the last stage, the state becomes DONE and done goes to 1.
- hold_in[j] for j > k is ignored until stage j is reached.
- In DONE: rst_out is all zero and done is 1.
- Re-arm applies in WAIT(k) for any j < k, and in DONE for any j:
  - Trigger: hold_in[j] high on an already-released stage.
  - At that edge: stage becomes j, rst_out[NUM_STAGES-1:j] is set to all ones, the counter clears, and done goes to 0.
  - Lower stages stay released.
- Simultaneous re-arm requests: the lowest j wins.
- Re-arm has priority over an advance in the same cycle.
- D_k = 0 releases stage k after one low cycle.
- The counter never wraps, because the compare is an equality and D_k fits in CNT_W bits.

## Timing
- Let t0 be the first WAIT(k) cycle with hold_in[k] low, continuously low from then on.
  - rst_out[k] is low from cycle t0+D_k+1.
  - stage = k+1 from that same cycle.
  - Stage k+1 counting begins in that cycle.
- With all holds low and rst_n released, rst_out[k] falls (k+1)*(D+1) cycles after the first cycle with rst_n high (uniform D).
- Re-arm latency: outputs assert 1 cycle after hold_in[j] is sampled high.
- rst_n latency: outputs assert 1 cycle after rst_n is sampled low.
- Outputs are direct flop outputs with no combinational path from the inputs.

## Configuration
- RESET_SEQ_TIMEOUT_EN defined:
  - A 32-bit counter counts consecutive cycles in WAIT(k) with hold_in[k] high.
  - The counter clears on a hold-low cycle, on a stage change, or on reset.
  - On the edge where it reaches TIMEOUT, timeout_flag[k] is set.
  - The flag stays set until rst_n. It has no effect on sequencing.
- RESET_SEQ_TIMEOUT_EN undefined: no timeout logic is built and timeout_flag is tied to zero.

## Test plan
- Default parameters, hold_in=0, rst_n released at cycle 0:
  - rst_out[0] is low from cycle 11, rst_out[1] from cycle 22, rst_out[2] from cycle 33.
  - done=1 and stage=3 at cycle 33.
- Stage 1 counting, hold_in[1] high for 5 cycles at count 6 -> counter restarts; rst_out[1] falls 11 cycles after hold_in[1] drops.
- In DONE, hold_in[0] pulsed for 1 cycle:
  - Next cycle: rst_out=3'b111, stage=0, done=0.
  - Full 33-cycle resequence follows.
- In DONE, hold_in[1] and hold_in[2] high in the same cycle -> stage=1, rst_out=3'b110, rst_out[0] stays 0.
- rst_n low for 1 cycle while in WAIT(2) -> next cycle rst_out=3'b111, stage=0, done=0.
- TIMEOUT=20, macro defined, hold_in[0] high for 25 cycles:
  - timeout_flag[0]=1 from cycle 21 and stays set after hold_in drops.
  - With the macro undefined, timeout_flag stays 0.
